mmu_cache_ctrl: RTL
===================

Name: mmu_cache_ctrl

Overview:
- Parametrised next-generation MMU cache controller: direct-mapped, write-through, no-write-allocate, between the core load/store unit and the AXI master request port (axi_rd_*/axi_wr_* handshakes).
- Adds over the previous generation: configurable line count and address width, per-func3 byte/half/word access (sign/zero extension, write strobes), misalignment detection, explicit ready signals, single-cycle flush.

Parameters:
- NUM_LINES, 16, number of one-word cache lines; power of 2, >= 2; INDEX_W = clog2(NUM_LINES).
- ADDR_W, 32, byte address width; TAG_W = ADDR_W - INDEX_W - 2.
- REG_W, 5, width of the destination-register tag carried through.

Ports:
- mmu_clk  in  1  clock, single clock domain
- i_rstn  in  1  synchronous active-low reset
- flush  in  1  invalidate all lines
- rd_req  in  1  load request; held until accepted
- rd_ready  out  1  idle & ~flush & ~wr_req
- rd_addr  in  ADDR_W  load byte address
- rd_req_reg  in  REG_W  destination register tag
- rd_req_func3  in  3  load type
- rd_data  out  32  extended load result
- rd_valid  out  1  1-cycle pulse, load complete
- rd_valid_reg  out  REG_W  captured rd_req_reg
- rd_valid_func3  out  3  captured rd_req_func3
- wr_req  in  1  store request; held until accepted
- wr_ready  out  1  idle & ~flush
- wr_addr  in  ADDR_W  store byte address
- wr_data  in  32  store data, LSB-aligned
- wr_func3  in  3  store type
- wr_req_reg  in  REG_W  tag returned with wr_done
- wr_done  out  1  1-cycle pulse, store complete
- wr_done_reg  out  REG_W  captured wr_req_reg
- misalign_err  out  1  pulses with rd_valid/wr_done when access is illegal
- axi_rd_rq  out  1  backend read request
- axi_rd_addr  out  ADDR_W  word-aligned read address
- axi_rd_data  in  32  backend read data
- axi_rd_valid  in  1  backend read data valid
- axi_rd_valid_ack  out  1  1-cycle ack of axi_rd_valid
- axi_wr_rq  out  1  backend write request
- axi_wr_addr  out  ADDR_W  word-aligned write address
- axi_wr_data  out  32  lane-replicated write data
- axi_wr_strb  out  4  byte strobes
- axi_wr_rq_ack  in  1  backend accepted write request
- axi_wr_done  in  1  backend write response
- axi_wr_done_ack  out  1  1-cycle ack of axi_wr_done

Behaviour:
- Reset (i_rstn=0 at edge): state IDLE; all valid bits 0; every output 0 except rd_ready/wr_ready, which follow their equations. Reset mid-transaction abandons it without ack; the backend must tolerate this.
- Address split: index = addr[INDEX_W+1:2]; tag = addr[ADDR_W-1:INDEX_W+2]; off = addr[1:0].
- Arrays: data, tag and valid are flops.
- Priority in IDLE: flush > wr_req > rd_req. A flush cycle clears all valid bits at the next edge; no other effect.
- Legality: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
  - Illegal: LH/LHU/SH with off[0]=1; LW/SW with off!=0; any other func3.
  - Illegal access: no backend traffic, no cache update; 1 cycle after acceptance, rd_valid (rd_data=0) or wr_done pulses together with misalign_err.
- States: IDLE, RD_MISS, RD_RESP, WR_REQ, WR_WAIT, RESP.
- Load hit: rd_valid pulses 1 cycle after acceptance (via RESP); rd_data is the extracted, extended word.
- Load miss:
  - RD_MISS: axi_rd_rq=1 and axi_rd_addr={addr[ADDR_W-1:2],2'b00} from the cycle after acceptance until axi_rd_valid is sampled 1.
  - In that same cycle: axi_rd_valid_ack=1 (1 cycle), axi_rd_rq drops, line filled (tag, data, valid=1).
  - RD_RESP: rd_valid pulses the next cycle.
- Extraction: byte = word[8*off +: 8]; half = word[16*off[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend.
- Store:
  - Strobes: SB -> 4'b0001 << off; SH -> 4'b0011 << off; SW -> 4'b1111.
  - axi_wr_data = byte replicated x4 (SB), half x2 (SH), or the word (SW).
  - On a tag hit, the strobed bytes of the cache line are updated at the acceptance edge; a later load sees the new data. A miss does not allocate.
  - WR_REQ: axi_wr_rq held from the cycle after acceptance until axi_wr_rq_ack is sampled 1.
  - WR_WAIT: wait for axi_wr_done; in that cycle axi_wr_done_ack=1.
  - wr_done pulses the next cycle.
  - axi_wr_done coinciding with axi_wr_rq_ack is legal: ack it in that cycle and skip WR_WAIT.
- Request capture: rd_req_reg/func3 and wr_req_reg are captured at acceptance and returned unchanged.
- Busy: only one outstanding access; rd_ready/wr_ready are 0 outside IDLE. A flush asserted while busy waits until IDLE.
- Backend data arriving while not in RD_MISS is ignored and not acked.

Test Plan:
- After reset, LW 0x0000_0040, backend returns 0xDEADBEEF after 5 cycles -> axi_rd_addr=0x40, ack 1 cycle, rd_valid with 0xDEADBEEF and reg/func3 echoed; repeat LW -> hit, rd_valid 1 cycle after accept, no axi_rd_rq.
- Line 0x40 = 0xDEADBEEF: LB 0x43 -> 0xFFFFFFDE; LBU 0x43 -> 0x000000DE; LH 0x42 -> 0xFFFFDEAD; LHU 0x40 -> 0x0000BEEF.
- SB 0x41 data 0x12 on cached line -> axi_wr_strb=4'b0010, axi_wr_data=0x12121212, wr_done after done-ack; then LW 0x40 hits with 0xDEAD12EF.
- LH 0x41, SW 0x42, func3=011 -> misalign_err with rd_valid/wr_done 1 cycle after accept, rd_data=0, no backend requests.
- wr_req and rd_req together in IDLE -> store served first, rd_ready=0 until IDLE, then load served; aliasing addresses 0x40 and 0x80 (NUM_LINES=16) evict each other.
- Flush after fills, then LW 0x40 -> miss, backend read reissued; reset asserted during RD_MISS -> next cycle axi_rd_rq=0, all outputs 0, next LW 0x40 misses.

Source files
------------

// File: rtl/mmu_cache_ctrl_if.sv
// Bundle of the load/store unit request bus, flush and the backend AXI request port.
// The controller uses the slave view; the core/backend environment uses the master view.
interface mmu_cache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
);
    logic              flush;
    logic              rd_req;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [REG_W-1:0]  rd_req_reg;
    logic [2:0]        rd_req_func3;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic [REG_W-1:0]  rd_valid_reg;
    logic [2:0]        rd_valid_func3;
    logic              wr_req;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [2:0]        wr_func3;
    logic [REG_W-1:0]  wr_req_reg;
    logic              wr_done;
    logic [REG_W-1:0]  wr_done_reg;
    logic              misalign_err;
    logic              axi_rd_rq;
    logic [ADDR_W-1:0] axi_rd_addr;
    logic [31:0]       axi_rd_data;
    logic              axi_rd_valid;
    logic              axi_rd_valid_ack;
    logic              axi_wr_rq;
    logic [ADDR_W-1:0] axi_wr_addr;
    logic [31:0]       axi_wr_data;
    logic [3:0]        axi_wr_strb;
    logic              axi_wr_rq_ack;
    logic              axi_wr_done;
    logic              axi_wr_done_ack;

    modport slave (
        input  flush, rd_req, rd_addr, rd_req_reg, rd_req_func3,
               wr_req, wr_addr, wr_data, wr_func3, wr_req_reg,
               axi_rd_data, axi_rd_valid, axi_wr_rq_ack, axi_wr_done,
        output rd_ready, rd_data, rd_valid, rd_valid_reg, rd_valid_func3,
               wr_ready, wr_done, wr_done_reg, misalign_err,
               axi_rd_rq, axi_rd_addr, axi_rd_valid_ack,
               axi_wr_rq, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_done_ack
    );

    modport master (
        output flush, rd_req, rd_addr, rd_req_reg, rd_req_func3,
               wr_req, wr_addr, wr_data, wr_func3, wr_req_reg,
               axi_rd_data, axi_rd_valid, axi_wr_rq_ack, axi_wr_done,
        input  rd_ready, rd_data, rd_valid, rd_valid_reg, rd_valid_func3,
               wr_ready, wr_done, wr_done_reg, misalign_err,
               axi_rd_rq, axi_rd_addr, axi_rd_valid_ack,
               axi_wr_rq, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_done_ack
    );
endinterface

// File: rtl/mmu_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache of one-word lines between
// the load/store unit and the AXI request port; one outstanding access at a time.
module mmu_cache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32,
    parameter int REG_W     = 5
) (
    input  logic            mmu_clk,
    input  logic            i_rstn,
    mmu_cache_ctrl_if.slave bus
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_MISS = 3'd1,
        RD_RESP = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: load_legal = 1'b1;
            3'b001, 3'b101: load_legal = ~off[0];
            3'b010:         load_legal = (off == 2'b00);
            default:        load_legal = 1'b0;
        endcase
    endfunction

    function automatic logic store_legal(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  store_legal = 1'b1;
            3'b001:  store_legal = ~off[0];
            3'b010:  store_legal = (off == 2'b00);
            default: store_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'h00_0000, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'h0000, h};
            3'b010:  load_extract = word;
            default: load_extract = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  store_strobe = 4'b0001 << off;
            3'b001:  store_strobe = 4'b0011 << off;
            3'b010:  store_strobe = 4'b1111;
            default: store_strobe = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  store_lanes = {4{d[7:0]}};
            3'b001:  store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    state_t               state_r;
    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [31:0]          data_r [NUM_LINES];
    logic [1:0]           req_off_r;

    logic [31:0]       rd_data_r;
    logic              rd_valid_r;
    logic [REG_W-1:0]  rd_valid_reg_r;
    logic [2:0]        rd_valid_func3_r;
    logic              wr_done_r;
    logic [REG_W-1:0]  wr_done_reg_r;
    logic              misalign_err_r;
    logic              axi_rd_rq_r;
    logic [ADDR_W-1:0] axi_rd_addr_r;
    logic              axi_wr_rq_r;
    logic [ADDR_W-1:0] axi_wr_addr_r;
    logic [31:0]       axi_wr_data_r;
    logic [3:0]        axi_wr_strb_r;

    logic [INDEX_W-1:0] rd_idx_s, wr_idx_s, fill_idx_s;
    logic [TAG_W-1:0]   rd_tag_s, wr_tag_s;
    logic [1:0]         rd_off_s, wr_off_s;
    logic               rd_hit_s, wr_hit_s, rd_legal_s, wr_legal_s;
    logic [3:0]         wr_strb_s;
    logic [31:0]        wr_lanes_s;

    assign rd_idx_s   = bus.rd_addr[INDEX_W+1:2];
    assign rd_tag_s   = bus.rd_addr[ADDR_W-1:INDEX_W+2];
    assign rd_off_s   = bus.rd_addr[1:0];
    assign wr_idx_s   = bus.wr_addr[INDEX_W+1:2];
    assign wr_tag_s   = bus.wr_addr[ADDR_W-1:INDEX_W+2];
    assign wr_off_s   = bus.wr_addr[1:0];
    assign fill_idx_s = axi_rd_addr_r[INDEX_W+1:2];
    assign rd_hit_s   = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
    assign wr_hit_s   = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s);
    assign rd_legal_s = load_legal(bus.rd_req_func3, rd_off_s);
    assign wr_legal_s = store_legal(bus.wr_func3, wr_off_s);
    assign wr_strb_s  = store_strobe(bus.wr_func3, wr_off_s);
    assign wr_lanes_s = store_lanes(bus.wr_func3, bus.wr_data);

    // Controller FSM, cache arrays and all registered outputs.
    always_ff @(posedge mmu_clk) begin
        if (!i_rstn) begin
            state_r          <= IDLE;
            valid_r          <= '0;
            req_off_r        <= 2'b00;
            rd_data_r        <= 32'h0000_0000;
            rd_valid_r       <= 1'b0;
            rd_valid_reg_r   <= '0;
            rd_valid_func3_r <= 3'b000;
            wr_done_r        <= 1'b0;
            wr_done_reg_r    <= '0;
            misalign_err_r   <= 1'b0;
            axi_rd_rq_r      <= 1'b0;
            axi_rd_addr_r    <= '0;
            axi_wr_rq_r      <= 1'b0;
            axi_wr_addr_r    <= '0;
            axi_wr_data_r    <= 32'h0000_0000;
            axi_wr_strb_r    <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.flush) begin
                        valid_r <= '0;
                    end else if (bus.wr_req) begin
                        wr_done_reg_r <= bus.wr_req_reg;
                        if (!wr_legal_s) begin
                            wr_done_r      <= 1'b1;
                            misalign_err_r <= 1'b1;
                            state_r        <= RESP;
                        end else begin
                            // Write-through: a hit merges the strobed lanes, a miss leaves the cache alone.
                            if (wr_hit_s) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (wr_strb_s[b]) begin
                                        data_r[wr_idx_s][8*b +: 8] <= wr_lanes_s[8*b +: 8];
                                    end
                                end
                            end
                            axi_wr_rq_r   <= 1'b1;
                            axi_wr_addr_r <= {bus.wr_addr[ADDR_W-1:2], 2'b00};
                            axi_wr_data_r <= wr_lanes_s;
                            axi_wr_strb_r <= wr_strb_s;
                            state_r       <= WR_REQ;
                        end
                    end else if (bus.rd_req) begin
                        rd_valid_reg_r   <= bus.rd_req_reg;
                        rd_valid_func3_r <= bus.rd_req_func3;
                        req_off_r        <= rd_off_s;
                        if (!rd_legal_s) begin
                            rd_valid_r     <= 1'b1;
                            rd_data_r      <= 32'h0000_0000;
                            misalign_err_r <= 1'b1;
                            state_r        <= RESP;
                        end else if (rd_hit_s) begin
                            rd_valid_r <= 1'b1;
                            rd_data_r  <= load_extract(data_r[rd_idx_s], rd_off_s, bus.rd_req_func3);
                            state_r    <= RESP;
                        end else begin
                            axi_rd_rq_r   <= 1'b1;
                            axi_rd_addr_r <= {bus.rd_addr[ADDR_W-1:2], 2'b00};
                            state_r       <= RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    if (bus.axi_rd_valid) begin
                        axi_rd_rq_r         <= 1'b0;
                        valid_r[fill_idx_s] <= 1'b1;
                        tag_r[fill_idx_s]   <= axi_rd_addr_r[ADDR_W-1:INDEX_W+2];
                        data_r[fill_idx_s]  <= bus.axi_rd_data;
                        rd_valid_r          <= 1'b1;
                        rd_data_r           <= load_extract(bus.axi_rd_data, req_off_r, rd_valid_func3_r);
                        state_r             <= RD_RESP;
                    end
                end
                WR_REQ: begin
                    if (bus.axi_wr_rq_ack) begin
                        axi_wr_rq_r <= 1'b0;
                        if (bus.axi_wr_done) begin
                            wr_done_r <= 1'b1;
                            state_r   <= RESP;
                        end else begin
                            state_r <= WR_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (bus.axi_wr_done) begin
                        wr_done_r <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                RD_RESP, RESP: begin
                    rd_valid_r     <= 1'b0;
                    wr_done_r      <= 1'b0;
                    misalign_err_r <= 1'b0;
                    state_r        <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_ready         = (state_r == IDLE) & ~bus.flush & ~bus.wr_req;
    assign bus.wr_ready         = (state_r == IDLE) & ~bus.flush;
    assign bus.axi_rd_valid_ack = (state_r == RD_MISS) & bus.axi_rd_valid;
    assign bus.axi_wr_done_ack  = ((state_r == WR_WAIT) | ((state_r == WR_REQ) & bus.axi_wr_rq_ack))
                                  & bus.axi_wr_done;
    assign bus.rd_data          = rd_data_r;
    assign bus.rd_valid         = rd_valid_r;
    assign bus.rd_valid_reg     = rd_valid_reg_r;
    assign bus.rd_valid_func3   = rd_valid_func3_r;
    assign bus.wr_done          = wr_done_r;
    assign bus.wr_done_reg      = wr_done_reg_r;
    assign bus.misalign_err     = misalign_err_r;
    assign bus.axi_rd_rq        = axi_rd_rq_r;
    assign bus.axi_rd_addr      = axi_rd_addr_r;
    assign bus.axi_wr_rq        = axi_wr_rq_r;
    assign bus.axi_wr_addr      = axi_wr_addr_r;
    assign bus.axi_wr_data      = axi_wr_data_r;
    assign bus.axi_wr_strb      = axi_wr_strb_r;
endmodule
